// File: rtl/clk_div_gen.sv
// clk_div_gen: integer clock divider with glitch-free ratio updates.
// Optional define CLKDIV_TICK_EN enables the o_div_tick period marker.
module clk_div_gen #(
  parameter int WIDTH = 8
) (
  input  logic             i_ref_clk,
  input  logic             i_rst,
  input  logic             i_clk_en,
  input  logic [WIDTH-1:0] i_div_ratio,
  output logic             o_div_clk,
  output logic             o_div_tick,
  output logic             o_ratio_upd
);

  logic [WIDTH-1:0] act_ratio_q, act_ratio_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             q_q, q_d;
  logic             upd_q, upd_d;

  logic [WIDTH-1:0] half;
  logic [WIDTH-1:0] cnt_inc;
  logic             bypass;
  logic             last_cyc;
  logic             boundary;
  logic             new_ok;

  // Period bookkeeping shared by all registers
  always_comb begin
    half     = act_ratio_q >> 1;
    cnt_inc  = cnt_q + WIDTH'(1);
    bypass   = !i_clk_en || (act_ratio_q < WIDTH'(2));
    last_cyc = (act_ratio_q >= WIDTH'(2))
            && (cnt_q == act_ratio_q - WIDTH'(1));
    boundary = i_clk_en && (bypass || last_cyc);
    new_ok   = i_div_ratio >= WIDTH'(2);
  end

  // Next-state: adopt ratio at boundaries, otherwise step the period
  always_comb begin
    act_ratio_d = act_ratio_q;
    cnt_d       = cnt_q;
    q_d         = q_q;
    upd_d       = 1'b0;
    if (!i_clk_en) begin
      act_ratio_d = '0;
      cnt_d       = '0;
      q_d         = 1'b0;
    end else if (boundary) begin
      act_ratio_d = i_div_ratio;
      cnt_d       = '0;
      q_d         = new_ok;
      upd_d       = (i_div_ratio != act_ratio_q);
    end else begin
      cnt_d = cnt_inc;
      q_d   = (cnt_inc < half);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      act_ratio_q <= '0;
      cnt_q       <= '0;
      q_q         <= 1'b0;
      upd_q       <= 1'b0;
    end else begin
      act_ratio_q <= act_ratio_d;
      cnt_q       <= cnt_d;
      q_q         <= q_d;
      upd_q       <= upd_d;
    end
  end

`ifdef CLKDIV_TICK_EN
  logic tick_q, tick_d;

  // Tick marks the first cycle of each divided period
  always_comb begin
    tick_d = boundary && new_ok;
  end

  // Tick register
  always_ff @(posedge i_ref_clk) begin
    if (i_rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign o_div_tick = tick_q;
`else
  assign o_div_tick = 1'b0;
`endif

  // Bypass passes the reference clock straight through
  assign o_div_clk   = bypass ? i_ref_clk : q_q;
  assign o_ratio_upd = upd_q;

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: directed and random checks of clk_div_gen
// against a period-level reference model.
module tb_clk_div_gen;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic [W-1:0] ratio;
  logic         div_clk;
  logic         div_tick;
  logic         ratio_upd;

  int checks = 0;
  int passes = 0;

  // reference model: active ratio N and index c within period
  int m_n  = 0;
  int m_c  = 0;
  bit m_tick = 0;
  bit m_upd  = 0;

  clk_div_gen #(.WIDTH(W)) dut (
    .i_ref_clk  (clk),
    .i_rst      (rst),
    .i_clk_en   (en),
    .i_div_ratio(ratio),
    .o_div_clk  (div_clk),
    .o_div_tick (div_tick),
    .o_ratio_upd(ratio_upd)
  );

  always #5 clk = ~clk;

  task automatic chk(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s obs=%b exp=%b t=%0t",
                tag, obs, exp, $time);
  endtask

  function automatic bit in_bypass();
    return !en || m_n < 2;
  endfunction

  // expected divided level: high for first floor(N/2) cycles
  function automatic logic exp_clk(logic ref_lvl);
    if (in_bypass()) return ref_lvl;
    return (m_c < m_n / 2) ? 1'b1 : 1'b0;
  endfunction

  task automatic cyc();
    @(posedge clk);
    if (rst || !en) begin
      m_n = 0; m_c = 0; m_tick = 0; m_upd = 0;
    end else if (m_n < 2 || m_c == m_n - 1) begin
      m_upd  = (int'(ratio) != m_n);
      m_n    = int'(ratio);
      m_c    = 0;
      m_tick = (m_n >= 2);
    end else begin
      m_c++;
      m_tick = 0;
      m_upd  = 0;
    end
    #1;
    chk("div_clk_hi", div_clk, exp_clk(1'b1));
`ifdef CLKDIV_TICK_EN
    chk("tick", div_tick, m_tick);
`else
    chk("tick", div_tick, 1'b0);
`endif
    chk("upd", ratio_upd, m_upd);
    @(negedge clk);
    #1;
    chk("div_clk_lo", div_clk, exp_clk(1'b0));
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  // advance until model is at index c of a period of ratio n
  task automatic wait_pos(int n, int c, string tag);
    int k;
    k = 0;
    while (!(m_n == n && m_c == c) && k < 600) begin
      cyc();
      k++;
    end
    if (k >= 600) begin
      checks++;
      $error("FAIL wait_%s obs=timeout exp=reached", tag);
    end
  endtask

  initial begin
    rst   = 1'b1;
    en    = 1'b0;
    ratio = '0;
    run(2);
    rst = 1'b0;
    run(2);

    en = 1'b1; ratio = 8'd4;
    run(13);
    ratio = 8'd5;
    run(16);
    ratio = 8'd2;
    run(8);
    ratio = 8'd255;
    run(520);

    ratio = 8'd6;
    wait_pos(6, 2, "n6c2");
    ratio = 8'd3;
    run(12);

    ratio = 8'd0;
    run(6);
    ratio = 8'd1;
    run(6);

    ratio = 8'd8;
    wait_pos(8, 3, "n8c3");
    en = 1'b0;
    #1;
    chk("drop_now", div_clk, clk);
    run(4);
    en = 1'b1;
    run(12);

    ratio = 8'd4;
    wait_pos(4, 2, "n4c2");
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    run(10);

    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 19) == 0)
        ratio = 8'($urandom_range(0, 12));
      if ($urandom_range(0, 199) == 0)
        ratio = 8'($urandom_range(200, 255));
      if ($urandom_range(0, 39) == 0)
        en = ~en;
      rst = ($urandom_range(0, 149) == 0);
      cyc();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_gen.md
# clk_div_gen

Parametrised integer clock divider, the next generation of the UART baud-clock divider. It generates a divided clock from `i_ref_clk` for any ratio from 2 to 2^WIDTH−1, with a defined duty cycle for both even and odd ratios. The new ratio is adopted only at a period boundary, so a ratio change never produces a runt pulse. Ratios 0/1, or a deasserted enable, bypass the divider and pass the reference clock straight through. It feeds the UART TX/RX prescalers.

## Interface
- WIDTH, 8: width of ratio input, active-ratio register and cycle counter.
- i_ref_clk  in  1  reference clock; all registers use its rising edge.
- i_rst  in  1  reset; synchronous, active-high.
- i_clk_en  in  1  divider enable; 0 = bypass.
- i_div_ratio  in  WIDTH  requested division ratio N; sampled only at period boundaries.
- o_div_clk  out  1  divided clock, or i_ref_clk in bypass.
- o_div_tick  out  1  one-ref-cycle pulse marking the first cycle of each divided period (see Configuration).
- o_ratio_upd  out  1  one-cycle pulse: newly adopted ratio differs from the previous one.

## Operation
- Registers:
  - act_ratio (WIDTH): active ratio N.
  - cnt (WIDTH): cycle index c within the period, 0..N−1.
  - q: divided-clock phase.
  - tick, upd.
- H = act_ratio >> 1 (floor). Within one period, q is high for c < H and low for H ≤ c ≤ N−1.
  - Even N: 50 % duty.
  - Odd N: high H, low H+1. Every period is identical; there is no alternating pattern.
- Bypass condition is !i_clk_en || act_ratio < 2.
  - In bypass, o_div_clk = i_ref_clk (combinational mux) and q is held 0.
  - Every enabled bypass cycle is a boundary: act_ratio is resampled each edge.
- Boundary edge: an edge where cnt == act_ratio−1, or where the block is in bypass with i_clk_en = 1. At a boundary edge:
  - act_ratio ← i_div_ratio.
  - cnt ← 0.
  - q ← 1 if the sampled ratio ≥ 2, otherwise 0.
  - tick ← (sampled ratio ≥ 2).
  - upd ← (sampled ratio ≠ old act_ratio).
- Non-boundary edge (enabled, dividing):
  - cnt ← cnt+1.
  - q ← (cnt+1 < H).
  - tick ← 0, upd ← 0.
- i_clk_en = 0 at an edge: cnt ← 0, q ← 0, tick ← 0, upd ← 0, act_ratio ← 0. The block stays in bypass until re-enabled.
- Arithmetic: all comparisons are unsigned WIDTH-bit. N = 2^WIDTH−1 is the maximum and needs no extra counter bit. N−1 is never evaluated with N < 2.

## Timing
- Reset values, asserted at the first edge with i_rst = 1:
  - act_ratio = 0, cnt = 0, q = 0, tick = 0, upd = 0.
  - Hence o_div_clk follows i_ref_clk; o_div_tick = 0; o_ratio_upd = 0.
- Reset has priority over i_clk_en. Reset mid-period aborts the period immediately with no completion.
- Start-up: the first edge after reset with i_clk_en = 1 and i_div_ratio ≥ 2 is a boundary edge. o_div_clk rises registered, one edge after bypass is exited. tick and upd are high in that same cycle.
- Ratio change mid-period: the current period completes with the old N. The new N takes effect from the next boundary, and o_ratio_upd pulses with that first new-period cycle.
- Latency from i_div_ratio change to adoption: 1 to N_old edges.
- Enable drop: o_div_clk switches to i_ref_clk in the same cycle. This is a combinational mux, and the glitch risk is accepted, as in the previous divider.

## Configuration
- CLKDIV_TICK_EN defined: o_div_tick is driven as specified.
- Not defined: the tick register is removed and o_div_tick is tied 0. All other behaviour is identical.

## Test plan
- Reset, then i_clk_en = 1, N = 4: o_div_clk repeats 1,1,0,0 per ref cycle. o_div_tick is high every 4th cycle. o_ratio_upd pulses once.
- N = 5: pattern 1,1,0,0,0 repeated, identical every period. With N = 2: pattern 1,0.
- WIDTH = 8, N = 255: high 127 cycles, low 128 cycles, tick period 255. No counter overflow.
- N = 6, change i_div_ratio to 3 at c = 2: the remaining old period completes (6 cycles total). The next period is 1,0,0, with o_ratio_upd = 1 in its first cycle.
- N = 0 or 1, or i_clk_en = 0: o_div_clk equals i_ref_clk, tick = 0. Drop enable at c = 3 of N = 8: bypass is immediate. On re-enable, a fresh period starts at c = 0.
- Assert i_rst at c = 2 of N = 4 while i_clk_en = 1: at the next edge all registers are at reset values and the output is in bypass. After release, the divider restarts with q = 1 at the first edge.
